// File: rtl/lsu_mem_ctrl.sv
// Load/store front-end for the word-addressed ram block.
// Byte-addressed byte/half/word requests; sub-word stores are read-modify-write.
module lsu_mem_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_write,
  output logic                  ram_read,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);
  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int CW        = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_MERGE, S_WR, S_RESP} state_t;

  // Fields of the accepted request still needed after accept.
  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  lane;
    logic [15:0] wdata;
  } req_t;

  state_t        state;
  req_t          r_q;
  logic [CW-1:0] cnt;
  logic          req_err;

  assign req_ready = (state == S_IDLE);

  // Misaligned half/word or the reserved size code.
  always_comb begin
    req_err = (req_size == 2'd3) ||
              (req_size == 2'd1 && req_addr[0]) ||
              (req_size == 2'd2 && req_addr[1:0] != 2'b00);
  end

  // Per-lane merge of store data into the word just read back.
  logic [NUM_LANES-1:0][7:0] rd_b, mrg_b;
  assign rd_b = ram_data_out;

  genvar l;
  for (l = 0; l < NUM_LANES; l++) begin : g_lane
    logic       sel;
    logic [7:0] wb;
    assign sel      = (r_q.size == 2'd0) ? (r_q.lane == 2'(l)) : (r_q.lane[1] == 1'(l >> 1));
    assign wb       = (r_q.size == 2'd0 || (l % 2) == 0) ? r_q.wdata[7:0] : r_q.wdata[15:8];
    assign mrg_b[l] = sel ? wb : rd_b[l];
  end

  // Load alignment and extension; half loads are aligned so lane[0] is 0.
  logic [15:0]           sh;
  logic [DATA_WIDTH-1:0] ld;
  assign sh = 16'(ram_data_out >> {r_q.lane, 3'b000});

  // Select load result by size; sign bit gated by the unsigned flag.
  always_comb begin
    ld = ram_data_out;
    case (r_q.size)
      2'd0:    ld = {{(DATA_WIDTH-8){~r_q.uns & sh[7]}}, sh[7:0]};
      2'd1:    ld = {{(DATA_WIDTH-16){~r_q.uns & sh[15]}}, sh[15:0]};
      default: ld = ram_data_out;
    endcase
  end

  // Control FSM; every output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      r_q         <= '0;
      cnt         <= '0;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_rdata  <= '0;
      ram_read    <= 1'b0;
      ram_write   <= 1'b0;
      ram_address <= '0;
      ram_data_in <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            r_q         <= '{we: req_we, size: req_size, uns: req_unsigned,
                             lane: req_addr[1:0], wdata: req_wdata[15:0]};
            resp_rdata  <= '0;
            resp_err    <= req_err;
            if (req_err) begin
              resp_valid <= 1'b1;
              state      <= S_RESP;
            end else if (req_we && req_size == 2'd2) begin
              ram_address <= req_addr[ADDR_WIDTH+1:2];
              ram_data_in <= req_wdata;
              ram_write   <= 1'b1;
              state       <= S_WR;
            end else begin
              ram_address <= req_addr[ADDR_WIDTH+1:2];
              ram_read    <= 1'b1;
              state       <= S_RD;
            end
          end
        end
        S_RD: begin
          ram_read <= 1'b0;
          cnt      <= CW'(RD_LATENCY - 1);
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == '0) begin
            if (r_q.we) begin
              ram_data_in <= mrg_b;
              ram_write   <= 1'b1;
              state       <= S_MERGE;
            end else begin
              resp_rdata <= ld;
              resp_valid <= 1'b1;
              state      <= S_RESP;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_MERGE, S_WR: begin
          ram_write  <= 1'b0;
          resp_valid <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store front-end that sits directly upstream of the word-addressed `ram` block.
- Accepts byte-addressed CPU load/store requests (byte/half/word, signed/unsigned) over a valid/ready handshake.
- Drives `ram`'s address/data_in/write/read port and returns one aligned, extended response per request.
- Sub-word stores are done as read-modify-write, because `ram` has no byte enables.

Parameters:
- DATA_WIDTH, 32, RAM word width; fixed at 32 for RV32.
- ADDR_WIDTH, 16, RAM word-address width.
- RD_LATENCY, 1, cycles from the edge that samples ram_read to the edge where ram_data_out is valid (≥1).

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; high only in IDLE
- req_we  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
- req_unsigned  in  1  loads: zero-extend when 1, sign-extend when 0
- req_addr  in  ADDR_WIDTH+2  byte address
- req_wdata  in  DATA_WIDTH  store data, right-justified
- resp_valid  out  1  one-cycle response pulse; no backpressure
- resp_rdata  out  DATA_WIDTH  load result; 0 for stores and errors
- resp_err  out  1  misaligned or illegal size
- ram_address  out  ADDR_WIDTH  word address = req_addr[ADDR_WIDTH+1:2]
- ram_data_in  out  DATA_WIDTH  write data to RAM
- ram_write  out  1  RAM write strobe
- ram_read  out  1  RAM read strobe
- ram_data_out  in  DATA_WIDTH  RAM read data

Behaviour:
- All outputs are registered except req_ready, which is (state==IDLE).
- Reset values: state=IDLE; resp_valid, resp_err, ram_read, ram_write = 0; resp_rdata, ram_address, ram_data_in = 0.
- Accept: the request is captured at edge E0 where req_valid & req_ready. After E0, req_ready stays low until state returns to IDLE.
- States:
  - IDLE
  - RD: ram_read=1 for exactly one cycle
  - WAIT: count RD_LATENCY-1 cycles
  - MERGE: ram_write=1 with merged word for one cycle
  - WR: ram_write=1 with req_wdata for one cycle
  - RESP: resp_valid=1 for one cycle, then IDLE
- Transitions on accept:
  - Error (half with addr[0]=1, word with addr[1:0]≠0, or size=3) → RESP with err=1, rdata=0. No RAM strobe. resp_valid at E1.
  - Store word → WR → RESP. ram_write during E0..E1; resp_valid at E1+1.
  - Load → RD → WAIT → RESP. resp_valid high in the cycle starting at edge E0+1+RD_LATENCY+1 (L=1: 3 cycles after accept). rdata is captured from ram_data_out at the edge that enters RESP.
  - Store byte/half → RD → WAIT → MERGE → RESP. Only the addressed lane(s) of the read word are replaced; other bytes are preserved.
- Lane select is little-endian: byte lane = addr[1:0]; half lane = addr[1].
- Extension:
  - signed LB: bit 7 replicated to [31:8]
  - signed LH: bit 15 replicated to [31:16]
  - unsigned: upper bits zero
  - LW: unchanged
- ram_address and ram_data_in hold their last values when no strobe is active.
- ram_read and ram_write are never high in the same cycle.
- req_valid while busy is ignored; requester holds request until req_ready.
- Address wrap: the top bits beyond ADDR_WIDTH+2 do not exist. Max address 2^(ADDR_WIDTH+2)-1 is legal.
- Reset mid-operation aborts the operation:
  - The next cycle has no strobes and no resp_valid, and state=IDLE.
  - A pending MERGE write is dropped.
  - Any RAM read already issued is ignored.

Test Plan:
- SW addr 0x0010 data 0xDEADBEEF → single ram_write cycle, ram_address=0x0004, ram_data_in=0xDEADBEEF, resp_valid 2 cycles after accept, rdata=0, err=0. Then LW 0x0010 → rdata 0xDEADBEEF exactly 3 cycles after accept (RD_LATENCY=1).
- With 0xDEADBEEF at 0x0010:
  - LB 0x0013 → 0xFFFFFFDE
  - LBU 0x0013 → 0x000000DE
  - LH 0x0012 → 0xFFFFDEAD
  - LHU 0x0010 → 0x0000BEEF
  - LB 0x0010 → 0xFFFFFFEF
- SB 0x0011 data 0x00000055 → one ram_read, then one ram_write of 0xDEAD55EF. Then SH 0x0012 data 0x1234 → ram_write 0x123455EF. LW 0x0010 → 0x123455EF.
- Errors:
  - SH 0x0013 → resp_err=1, rdata=0, resp_valid 1 cycle after accept, no ram_read/ram_write.
  - LW 0x0012 → same.
  - req_size=3 → same.
- Hold req_valid high across back-to-back LW/SW → req_ready low while busy, each request accepted exactly once, responses in order, no strobe overlap.
- Assert rst for one cycle during WAIT of an SB → no ram_write ever issued, no resp_valid, req_ready=1 the cycle after reset. A following LW returns the unmodified word.
